// File: rtl/prog_mem_sync.sv
// Synchronous instruction memory with a valid/ready fetch port, programmable wait states
// and a loader write port. Define PROG_MEM_PARITY_EN to add per-word even parity.
module prog_mem_sync #(
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter int unsigned       WAIT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [DATA_W-1:0] rsp_word,
    output logic              rsp_valid,
    output logic              rsp_fault,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_fault,
`ifdef PROG_MEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic [31:0]       fetch_cnt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    // Parameter sanity checks
    if (DEPTH < 2) begin : g_depth_chk
        $error("prog_mem_sync: DEPTH must be at least 2");
    end
    if (WAIT > 7) begin : g_wait_chk
        $error("prog_mem_sync: WAIT must be in 0..7");
    end
    if (ADDR_W < 64) begin : g_range_chk
        if ((64'(BASE) + 64'(DEPTH)) > (64'd1 << ADDR_W)) begin : g_overflow
            $error("prog_mem_sync: BASE+DEPTH overflows the address space");
        end
    end

    logic [MEM_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] rd_off, wr_off;
    logic              rd_in, wr_in;
    logic [MEM_W-1:0]  rd_raw;
    logic [DATA_W-1:0] rd_word;
    logic              accept;

    logic [1:0]        state_q, state_d;
    logic [2:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] lat_word_q, lat_word_d;
    logic              lat_fault_q, lat_fault_d;
    logic [DATA_W-1:0] rsp_word_q, rsp_word_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic              wr_fault_q;
    logic [31:0]       fetch_cnt_q;
`ifdef PROG_MEM_PARITY_EN
    logic              rd_perr;
    logic              lat_perr_q, lat_perr_d;
    logic              perr_q, perr_d;
`endif

    // Underflow of the subtraction is caught by the explicit >= BASE term
    assign rd_off  = req_addr - BASE;
    assign wr_off  = wr_addr - BASE;
    assign rd_in   = (req_addr >= BASE) && (64'(rd_off) < 64'(DEPTH));
    assign wr_in   = (wr_addr >= BASE) && (64'(wr_off) < 64'(DEPTH));
    assign rd_raw  = mem[rd_off[IDX_W-1:0]];
    assign rd_word = rd_raw[DATA_W-1:0];
`ifdef PROG_MEM_PARITY_EN
    assign rd_perr = rd_in && (^rd_raw);
`endif

    assign req_ready = (state_q == StIdle) || ((state_q == StResp) && (WAIT == 0));
    assign rsp_valid = (state_q == StResp);
    assign accept    = req_valid && req_ready;

    // Loader writes ignore reset and the fetch FSM entirely
    always_ff @(posedge clk) begin
        if (wr_en && wr_in) begin
`ifdef PROG_MEM_PARITY_EN
            mem[wr_off[IDX_W-1:0]] <= {^wr_data, wr_data};
`else
            mem[wr_off[IDX_W-1:0]] <= wr_data;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        lat_word_d  = lat_word_q;
        lat_fault_d = lat_fault_q;
        rsp_word_d  = rsp_word_q;
        rsp_fault_d = rsp_fault_q;
`ifdef PROG_MEM_PARITY_EN
        lat_perr_d  = lat_perr_q;
        perr_d      = 1'b0;
`endif
        if (accept) begin
            lat_word_d  = rd_in ? rd_word : '0;
            lat_fault_d = !rd_in;
`ifdef PROG_MEM_PARITY_EN
            lat_perr_d  = rd_perr;
`endif
            if (WAIT == 0) begin
                state_d     = StResp;
                rsp_word_d  = rd_in ? rd_word : '0;
                rsp_fault_d = !rd_in;
`ifdef PROG_MEM_PARITY_EN
                perr_d      = rd_perr;
`endif
            end else begin
                state_d = StWait;
                wcnt_d  = 3'(WAIT);
            end
        end else begin
            unique case (state_q)
                StWait: begin
                    if (wcnt_q == 3'd1) begin
                        state_d     = StResp;
                        rsp_word_d  = lat_word_q;
                        rsp_fault_d = lat_fault_q;
`ifdef PROG_MEM_PARITY_EN
                        perr_d      = lat_perr_q;
`endif
                    end else begin
                        wcnt_d = wcnt_q - 3'd1;
                    end
                end
                StResp:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wcnt_q      <= '0;
            lat_word_q  <= '0;
            lat_fault_q <= 1'b0;
            rsp_word_q  <= '0;
            rsp_fault_q <= 1'b0;
            wr_fault_q  <= 1'b0;
            fetch_cnt_q <= '0;
`ifdef PROG_MEM_PARITY_EN
            lat_perr_q  <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            lat_word_q  <= lat_word_d;
            lat_fault_q <= lat_fault_d;
            rsp_word_q  <= rsp_word_d;
            rsp_fault_q <= rsp_fault_d;
            wr_fault_q  <= wr_en && !wr_in;
            if (accept && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
`ifdef PROG_MEM_PARITY_EN
            lat_perr_q  <= lat_perr_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign rsp_word  = rsp_word_q;
    assign rsp_fault = rsp_fault_q;
    assign wr_fault  = wr_fault_q;
    assign fetch_cnt = fetch_cnt_q;
`ifdef PROG_MEM_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_prog_mem_sync.sv
// Directed bench for prog_mem_sync: a WAIT=2 instance and a WAIT=0 instance,
// both DEPTH=512, BASE=0x100.
module tb_prog_mem_sync;

    logic        clk;
    logic        rst;

    logic [31:0] a_req_addr, a_rsp_word, a_wr_addr, a_wr_data, a_fetch_cnt;
    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_fault, a_wr_en, a_wr_fault;
    logic [31:0] b_req_addr, b_rsp_word, b_wr_addr, b_wr_data, b_fetch_cnt;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_fault, b_wr_en, b_wr_fault;
`ifdef PROG_MEM_PARITY_EN
    logic        a_parity_err, b_parity_err;
`endif

    int          n_checks;
    int          n_errors;
    int          exp_cnt_a;
    logic        exp_perr_a;

    prog_mem_sync #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(512), .BASE(32'h100), .WAIT(2)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (a_req_addr),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .rsp_word  (a_rsp_word),
        .rsp_valid (a_rsp_valid),
        .rsp_fault (a_rsp_fault),
        .wr_en     (a_wr_en),
        .wr_addr   (a_wr_addr),
        .wr_data   (a_wr_data),
        .wr_fault  (a_wr_fault),
`ifdef PROG_MEM_PARITY_EN
        .parity_err(a_parity_err),
`endif
        .fetch_cnt (a_fetch_cnt)
    );

    prog_mem_sync #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(512), .BASE(32'h100), .WAIT(0)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (b_req_addr),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .rsp_word  (b_rsp_word),
        .rsp_valid (b_rsp_valid),
        .rsp_fault (b_rsp_fault),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data),
        .wr_fault  (b_wr_fault),
`ifdef PROG_MEM_PARITY_EN
        .parity_err(b_parity_err),
`endif
        .fetch_cnt (b_fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [31:0] addr, input logic [31:0] data);
        a_wr_en   = 1'b1;
        a_wr_addr = addr;
        a_wr_data = data;
        tick();
        a_wr_en   = 1'b0;
    endtask

    task automatic write_b(input logic [31:0] addr, input logic [31:0] data);
        b_wr_en   = 1'b1;
        b_wr_addr = addr;
        b_wr_data = data;
        tick();
        b_wr_en   = 1'b0;
    endtask

    // Issues one fetch on dut_a (any a_wr_* already set rides on the accept edge) and
    // optionally writes during the first wait cycle. Expects the response 3 cycles later.
    task automatic fetch_a(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_word, input logic exp_fault,
                           input logic wait_wr, input logic [31:0] ww_addr,
                           input logic [31:0] ww_data);
        int n;
        a_req_addr  = addr;
        a_req_valid = 1'b1;
        check({tag, "_ready"}, 32'(a_req_ready), 32'd1);
        tick();
        a_req_valid = 1'b0;
        a_wr_en     = wait_wr;
        a_wr_addr   = ww_addr;
        a_wr_data   = ww_data;
        exp_cnt_a++;
        check({tag, "_busy"}, 32'(a_req_ready), 32'd0);
        n = 1;
        while (!a_rsp_valid && n < 10) begin
            tick();
            a_wr_en = 1'b0;
            n++;
        end
        a_wr_en = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_word"}, a_rsp_word, exp_word);
        check({tag, "_fault"}, 32'(a_rsp_fault), 32'(exp_fault));
        check({tag, "_cnt"}, a_fetch_cnt, 32'(exp_cnt_a));
`ifdef PROG_MEM_PARITY_EN
        check({tag, "_perr"}, 32'(a_parity_err), 32'(exp_perr_a));
`endif
        tick();
        check({tag, "_pulse"}, 32'(a_rsp_valid), 32'd0);
        check({tag, "_hold"}, a_rsp_word, exp_word);
    endtask

    initial begin
        logic seen;
        n_checks    = 0;
        n_errors    = 0;
        exp_cnt_a   = 0;
        exp_perr_a  = 1'b0;
        a_req_addr  = '0; a_req_valid = 1'b0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        b_req_addr  = '0; b_req_valid = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(a_req_ready), 32'd1);
        check("rst_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_word", a_rsp_word, 32'h0);
        check("rst_fault", 32'(a_rsp_fault), 32'd0);
        check("rst_wr_fault", 32'(a_wr_fault), 32'd0);
        check("rst_cnt", a_fetch_cnt, 32'd0);
        rst = 1'b0;
        tick();

        // Basic fetch with two wait states
        write_a(32'h100, 32'h0001_4888);
        fetch_a("t1", 32'h100, 32'h0001_4888, 1'b0, 1'b0, 32'h0, 32'h0);

        // Out-of-range fetches and writes
        write_a(32'h2FF, 32'hA5A5_0001);
        check("t2_wr_ok", 32'(a_wr_fault), 32'd0);
        fetch_a("t2_low", 32'h0FF, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        fetch_a("t2_high", 32'h300, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        write_a(32'h300, 32'h1234_5678);
        check("t2_wr_fault", 32'(a_wr_fault), 32'd1);
        tick();
        check("t2_wr_fault_pulse", 32'(a_wr_fault), 32'd0);
        fetch_a("t2_last", 32'h2FF, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch_a("t2_first", 32'h100, 32'h0001_4888, 1'b0, 1'b0, 32'h0, 32'h0);

        // Zero wait states: back-to-back fetches
        write_b(32'h100, 32'hDEAD_BEAF);
        write_b(32'h101, 32'h0000_000B);
        b_req_addr  = 32'h100;
        b_req_valid = 1'b1;
        check("t3_ready0", 32'(b_req_ready), 32'd1);
        tick();
        b_req_addr = 32'h101;
        check("t3_valid0", 32'(b_rsp_valid), 32'd1);
        check("t3_word0", b_rsp_word, 32'hDEAD_BEAF);
        check("t3_ready1", 32'(b_req_ready), 32'd1);
        tick();
        b_req_valid = 1'b0;
        check("t3_valid1", 32'(b_rsp_valid), 32'd1);
        check("t3_word1", b_rsp_word, 32'h0000_000B);
        tick();
        check("t3_idle", 32'(b_rsp_valid), 32'd0);
        check("t3_cnt", b_fetch_cnt, 32'd2);

        // Same-edge write returns old data; writes during wait do not disturb
        write_a(32'h105, 32'h2222_2222);
        a_wr_en   = 1'b1;
        a_wr_addr = 32'h105;
        a_wr_data = 32'h1111_1111;
        fetch_a("t4_old", 32'h105, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch_a("t4_new", 32'h105, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0);
        write_a(32'h106, 32'h3333_3333);
        fetch_a("t4_wait_wr", 32'h106, 32'h3333_3333, 1'b0, 1'b1, 32'h106, 32'h4444_4444);
        fetch_a("t4_wait_new", 32'h106, 32'h4444_4444, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset in the first wait cycle, with a write on the reset edge
        a_req_addr  = 32'h100;
        a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        rst       = 1'b1;
        a_wr_en   = 1'b1;
        a_wr_addr = 32'h107;
        a_wr_data = 32'h7777_7777;
        tick();
        rst     = 1'b0;
        a_wr_en = 1'b0;
        exp_cnt_a = 0;
        check("t5_ready", 32'(a_req_ready), 32'd1);
        check("t5_cnt", a_fetch_cnt, 32'd0);
        seen = a_rsp_valid;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | a_rsp_valid;
        end
        check("t5_no_rsp", 32'(seen), 32'd0);
        fetch_a("t5_mem", 32'h100, 32'h0001_4888, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch_a("t5_rst_wr", 32'h107, 32'h7777_7777, 1'b0, 1'b0, 32'h0, 32'h0);

`ifdef PROG_MEM_PARITY_EN
        // Corrupt a stored word behind the parity bit's back
        write_a(32'h108, 32'h0000_000F);
        dut_a.mem[8][0] = 1'b0;
        exp_perr_a = 1'b1;
        fetch_a("t6_perr", 32'h108, 32'h0000_000E, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_perr_a = 1'b0;
        check("t6_perr_pulse", 32'(a_parity_err), 32'd0);
        fetch_a("t6_oor", 32'h300, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
